// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master core: FSM states, SCL quarter
// phases, the R/W bit values and the byte-count clamp helper.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START,
        DEV_W,
        ACK1,
        REG,
        ACK2,
        WDATA,
        ACKW,
        RSTART,
        DEV_R,
        ACK3,
        RDATA,
        MACK,
        STOP
    } state_t;

    // SCL is low for the first two quarters of a bit and high for the last two
    localparam logic [1:0] PH_LOW0  = 2'd0;
    localparam logic [1:0] PH_LOW1  = 2'd1;
    localparam logic [1:0] PH_HIGH0 = 2'd2;
    localparam logic [1:0] PH_HIGH1 = 2'd3;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic [7:0] clamp_count(input logic [7:0] n, input int unsigned limit);
        if ({24'd0, n} > limit) begin
            return limit[7:0];
        end
        return n;
    endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: one tick every CLK_DIV cycles while enabled,
// and a 2-bit phase that advances on each tick; both park at zero when idle.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic       o_tick,
    output logic [1:0] o_phase
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_phase;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_phase <= PH_LOW0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= PH_LOW0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick  = i_en & w_wrap;
    assign o_phase = r_phase;

endmodule

// File: rtl/i2c_master_core.sv
// I2C master for register-style transfers: START, device address, register
// address, then either N write bytes or a repeated START and N read bytes.
module i2c_master_core
    import i2c_pkg::*;
#(
    parameter int CLK_DIV   = 250,
    parameter int MAX_BYTES = 255
) (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESET,
    input  logic       start_write,
    input  logic       start_read,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] num_bytes,
    input  logic [7:0] wr_data,
    output logic       req_data_chunk,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       nack,
    inout  wire        scl_io,
    inout  wire        sda_io
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_busy;
    logic        w_tick;
    logic [1:0]  w_phase;
    logic        w_bit_end;
    logic        w_sample;
    logic        w_start;
    logic        w_sda_in;
    logic        w_byte_last;
    logic        w_in_ack;
    logic        w_in_byte;
    logic [7:0]  w_cnt_load;

    logic        w_scl_low;
    logic        w_sda_low;
    logic        w_req;
    logic        w_rd_valid;

    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [7:0]  r_shift;
    logic        r_read;
    logic [7:0]  r_cnt;
    logic [2:0]  r_bit;
    logic        r_ack_bad;
    logic        r_nack;
    logic        r_req;
    logic        r_rd_valid;
    logic [7:0]  r_rd_data;
    logic        r_scl_low;
    logic        r_sda_low;

    assign w_busy      = (r_state != IDLE);
    assign w_start     = start_write | start_read;
    assign w_sda_in    = sda_io;
    assign w_bit_end   = w_tick & (w_phase == PH_HIGH1);
    assign w_sample    = w_tick & (w_phase == PH_HIGH0);
    assign w_byte_last = (r_bit == 3'd7);
    assign w_cnt_load  = clamp_count(num_bytes, MAX_BYTES);
    assign w_in_ack    = (r_state == ACK1) || (r_state == ACK2) ||
                         (r_state == ACK3) || (r_state == ACKW);
    assign w_in_byte   = (r_state == DEV_W) || (r_state == REG) || (r_state == WDATA) ||
                         (r_state == DEV_R) || (r_state == RDATA);

    i2c_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .i_clk   (S_AXI_ACLK),
        .i_rst   (S_AXI_ARESET),
        .i_en    (w_busy),
        .o_tick  (w_tick),
        .o_phase (w_phase)
    );

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transitions other than leaving IDLE happen only at the end of a bit period
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:   if (w_start) w_state_nxt = START;
            START:  if (w_bit_end) w_state_nxt = DEV_W;
            DEV_W:  if (w_bit_end && w_byte_last) w_state_nxt = ACK1;
            ACK1:   if (w_bit_end) w_state_nxt = r_ack_bad ? STOP : REG;
            REG:    if (w_bit_end && w_byte_last) w_state_nxt = ACK2;
            ACK2: begin
                if (w_bit_end) begin
                    if (r_ack_bad)       w_state_nxt = STOP;
                    else if (r_read)     w_state_nxt = RSTART;
                    else if (r_cnt == 0) w_state_nxt = STOP;
                    else                 w_state_nxt = WDATA;
                end
            end
            WDATA:  if (w_bit_end && w_byte_last) w_state_nxt = ACKW;
            ACKW:   if (w_bit_end) w_state_nxt = (r_ack_bad || r_cnt == 0) ? STOP : WDATA;
            RSTART: if (w_bit_end) w_state_nxt = DEV_R;
            DEV_R:  if (w_bit_end && w_byte_last) w_state_nxt = ACK3;
            ACK3:   if (w_bit_end) w_state_nxt = r_ack_bad ? STOP : RDATA;
            RDATA:  if (w_bit_end && w_byte_last) w_state_nxt = MACK;
            MACK:   if (w_bit_end) w_state_nxt = (r_cnt == 0) ? STOP : RDATA;
            STOP:   if (w_bit_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_scl_low  = 1'b0;
        w_sda_low  = 1'b0;
        w_req      = 1'b0;
        w_rd_valid = 1'b0;
        case (r_state)
            START: begin
                w_sda_low = w_phase[1];
                w_scl_low = (w_phase == PH_HIGH1);
            end
            // one low quarter lets the slave release its ACK before SDA rises
            RSTART: begin
                w_scl_low = (w_phase == PH_LOW0) || (w_phase == PH_HIGH1);
                w_sda_low = w_phase[1];
            end
            STOP: begin
                w_scl_low = ~w_phase[1];
                w_sda_low = (w_phase == PH_LOW1) || (w_phase == PH_HIGH0);
            end
            DEV_W, REG, WDATA, DEV_R: begin
                w_scl_low = ~w_phase[1];
                w_sda_low = ~r_shift[7];
            end
            ACK1, ACK3, RDATA: begin
                w_scl_low = ~w_phase[1];
            end
            ACK2: begin
                w_scl_low = ~w_phase[1];
                w_req     = w_bit_end & ~r_read & ~r_ack_bad & (r_cnt != 0);
            end
            ACKW: begin
                w_scl_low = ~w_phase[1];
                w_req     = w_bit_end & ~r_ack_bad & (r_cnt != 0);
            end
            MACK: begin
                w_scl_low = ~w_phase[1];
                w_sda_low = (r_cnt != 0);
            end
            default: ;
        endcase
        if (r_state == RDATA) begin
            w_rd_valid = w_bit_end & w_byte_last;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_read     <= 1'b0;
            r_cnt      <= 8'd0;
            r_bit      <= 3'd0;
            r_ack_bad  <= 1'b0;
            r_nack     <= 1'b0;
            r_req      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
            r_scl_low  <= 1'b0;
            r_sda_low  <= 1'b0;
        end else begin
            r_req      <= w_req;
            r_rd_valid <= w_rd_valid;
            r_scl_low  <= w_scl_low;
            r_sda_low  <= w_sda_low;
            if (r_state == IDLE && w_start) begin
                r_read <= ~start_write;
                r_cnt  <= (!start_write && w_cnt_load == 8'd0) ? 8'd1 : w_cnt_load;
                r_nack <= 1'b0;
            end
            if (w_sample) begin
                r_ack_bad <= w_sda_in;
                if (w_in_ack && w_sda_in) begin
                    r_nack <= 1'b1;
                end
            end
            if (w_bit_end && w_in_byte) begin
                r_bit <= r_bit + 3'd1;
                if (w_byte_last && (r_state == WDATA || r_state == RDATA) && r_cnt != 8'd0) begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end
            if (w_rd_valid) begin
                r_rd_data <= r_shift;
            end
        end
    end

    // Byte shifter: loaded per byte, shifts out at bit end, shifts in at SCL-high midpoint
    always_ff @(posedge S_AXI_ACLK) begin
        if (r_state == IDLE && w_start) begin
            r_dev   <= dev_addr;
            r_reg   <= reg_addr;
            r_shift <= {dev_addr, RW_WRITE};
        end
        if (w_sample && r_state == RDATA) begin
            r_shift <= {r_shift[6:0], w_sda_in};
        end
        if (w_bit_end) begin
            case (r_state)
                DEV_W, REG, WDATA, DEV_R: r_shift <= {r_shift[6:0], 1'b0};
                ACK1:                     r_shift <= r_reg;
                RSTART:                   r_shift <= {r_dev, RW_READ};
                default: ;
            endcase
        end
        if (r_req) begin
            r_shift <= wr_data;
        end
    end

    assign scl_io         = r_scl_low ? 1'b0 : 1'bz;
    assign sda_io         = r_sda_low ? 1'b0 : 1'bz;
    assign busy           = w_busy;
    assign nack           = r_nack;
    assign req_data_chunk = r_req;
    assign rd_valid       = r_rd_valid;
    assign rd_data        = r_rd_data;

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core with a behavioural I2C slave on a
// pulled-up open-drain bus.
module tb_i2c_master_core;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_write = 1'b0;
    logic       start_read = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] num_bytes = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic       req_data_chunk;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       nack;
    wire        scl_w;
    wire        sda_w;
    logic       s_low = 1'b0;

    pullup (scl_w);
    pullup (sda_w);
    assign sda_w = s_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_core #(
        .CLK_DIV   (CLK_DIV),
        .MAX_BYTES (255)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESET   (rst),
        .start_write    (start_write),
        .start_read     (start_read),
        .dev_addr       (dev_addr),
        .reg_addr       (reg_addr),
        .num_bytes      (num_bytes),
        .wr_data        (wr_data),
        .req_data_chunk (req_data_chunk),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .busy           (busy),
        .nack           (nack),
        .scl_io         (scl_w),
        .sda_io         (sda_w)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave / bus monitor state
    int         n_start = 0, n_stop = 0, n_log = 0, n_req = 0, n_rdv = 0, n_mack = 0;
    int         tx_idx = 0, mon_bit = 0, frame = 0;
    logic [7:0] log_b  [64];
    logic [7:0] rdv_b  [64];
    logic       mack_b [64];
    logic [7:0] wbytes [64];
    logic [7:0] src    [64];
    logic [7:0] rx = 8'd0;
    logic [7:0] tx_byte;
    logic       slave_tx = 1'b0, tx_active = 1'b0, nack_addr = 1'b0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1, cur_scl, cur_sda;

    always @(negedge clk) begin
        cur_scl = scl_w;
        cur_sda = sda_w;
        if (req_data_chunk) begin
            wr_data = wbytes[n_req];
            n_req++;
        end
        if (rd_valid) begin
            rdv_b[n_rdv] = rd_data;
            n_rdv++;
        end
        if (rst) begin
            s_low = 1'b0;
        end else if (prev_scl && cur_scl) begin
            if (prev_sda && !cur_sda) begin
                n_start++;
                mon_bit = 0; frame = 0; slave_tx = 1'b0; tx_active = 1'b1; s_low = 1'b0;
            end else if (!prev_sda && cur_sda) begin
                n_stop++;
                s_low = 1'b0;
            end
        end else if (!prev_scl && cur_scl) begin
            if (mon_bit < 8) begin
                if (!slave_tx) rx = {rx[6:0], cur_sda};
                mon_bit++;
            end else begin
                if (slave_tx) begin
                    mack_b[n_mack] = cur_sda;
                    n_mack++;
                    tx_idx++;
                    if (cur_sda) tx_active = 1'b0;
                end else begin
                    log_b[n_log] = rx;
                    n_log++;
                    if (frame == 0 && rx[0]) slave_tx = 1'b1;
                end
                frame++;
                mon_bit = 0;
            end
        end else if (prev_scl && !cur_scl) begin
            tx_byte = src[tx_idx];
            if (mon_bit == 8) s_low = !slave_tx && !(nack_addr && frame == 0);
            else if (slave_tx && tx_active) s_low = !tx_byte[7 - mon_bit];
            else s_low = 1'b0;
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    task automatic launch(input logic w, input logic r, input logic [6:0] d,
                          input logic [7:0] ra, input logic [7:0] n);
        @(posedge clk); #1;
        dev_addr = d; reg_addr = ra; num_bytes = n;
        start_write = w; start_read = r;
        @(posedge clk); #1;
        start_write = 1'b0; start_read = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(tag, busy, 1'b0);
    endtask

    int s0, p0, l0, q0, v0, m0, k;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_nack", nack, 1'b0);
        check("rst_req", req_data_chunk, 1'b0);
        check("rst_rdv", rd_valid, 1'b0);
        check("rst_rdata", rd_data, 8'h00);
        check("rst_scl", scl_w, 1'b1);
        check("rst_sda", sda_w, 1'b1);
        @(posedge clk); #1 rst = 1'b0;

        // Write with zero data bytes
        s0 = n_start; p0 = n_stop; l0 = n_log; q0 = n_req;
        launch(1'b1, 1'b0, 7'h5B, 8'h00, 8'd0);
        check("w0_busy_rise", busy, 1'b1);
        wait_idle("w0_done");
        check("w0_starts", n_start - s0, 1);
        check("w0_nbytes", n_log - l0, 2);
        check("w0_byte0", log_b[l0], 8'hB6);
        check("w0_byte1", log_b[l0 + 1], 8'h00);
        check("w0_stops", n_stop - p0, 1);
        check("w0_nack", nack, 1'b0);
        check("w0_reqs", n_req - q0, 0);

        // Write with two data bytes
        s0 = n_start; p0 = n_stop; l0 = n_log; q0 = n_req;
        wbytes[n_req] = 8'hA5; wbytes[n_req + 1] = 8'h3C;
        launch(1'b1, 1'b0, 7'h5B, 8'h10, 8'd2);
        wait_idle("w2_done");
        check("w2_reqs", n_req - q0, 2);
        check("w2_nbytes", n_log - l0, 4);
        check("w2_byte0", log_b[l0], 8'hB6);
        check("w2_byte1", log_b[l0 + 1], 8'h10);
        check("w2_byte2", log_b[l0 + 2], 8'hA5);
        check("w2_byte3", log_b[l0 + 3], 8'h3C);
        check("w2_stops", n_stop - p0, 1);
        check("w2_nack", nack, 1'b0);

        // Register read of two bytes
        s0 = n_start; p0 = n_stop; l0 = n_log; v0 = n_rdv; m0 = n_mack; q0 = n_req;
        src[tx_idx] = 8'hAB; src[tx_idx + 1] = 8'hCD;
        launch(1'b0, 1'b1, 7'h5B, 8'h05, 8'd2);
        wait_idle("r2_done");
        check("r2_starts", n_start - s0, 2);
        check("r2_nbytes", n_log - l0, 3);
        check("r2_byte0", log_b[l0], 8'hB6);
        check("r2_byte1", log_b[l0 + 1], 8'h05);
        check("r2_byte2", log_b[l0 + 2], 8'hB7);
        check("r2_rdv", n_rdv - v0, 2);
        check("r2_rd0", rdv_b[v0], 8'hAB);
        check("r2_rd1", rdv_b[v0 + 1], 8'hCD);
        check("r2_mack0", mack_b[m0], 1'b0);
        check("r2_mack1", mack_b[m0 + 1], 1'b1);
        check("r2_stops", n_stop - p0, 1);
        check("r2_reqs", n_req - q0, 0);
        check("r2_nack", nack, 1'b0);

        // Slave NACKs the address byte
        nack_addr = 1'b1;
        p0 = n_stop; l0 = n_log; q0 = n_req;
        launch(1'b1, 1'b0, 7'h5B, 8'h10, 8'd2);
        wait_idle("na_done");
        check("na_nack", nack, 1'b1);
        check("na_stops", n_stop - p0, 1);
        check("na_reqs", n_req - q0, 0);
        check("na_nbytes", n_log - l0, 1);
        nack_addr = 1'b0;

        // Reset during the register byte, then a clean write
        p0 = n_stop; l0 = n_log;
        launch(1'b1, 1'b0, 7'h5B, 8'h10, 8'd2);
        check("rs_nack_cleared", nack, 1'b0);
        k = 0;
        while (!(n_log == l0 + 1 && mon_bit >= 3) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("rs_reached_reg", n_log - l0, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rs_scl_z", scl_w, 1'b1);
        check("rs_sda_z", sda_w, 1'b1);
        check("rs_busy", busy, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rs_no_stop", n_stop - p0, 0);
        p0 = n_stop; l0 = n_log;
        launch(1'b1, 1'b0, 7'h5B, 8'h22, 8'd0);
        wait_idle("rs_after_done");
        check("rs_after_n", n_log - l0, 2);
        check("rs_after_b1", log_b[l0 + 1], 8'h22);
        check("rs_after_stop", n_stop - p0, 1);

        // Simultaneous start pulses, then a read pulse while busy
        s0 = n_start; p0 = n_stop; l0 = n_log; q0 = n_req; v0 = n_rdv;
        wbytes[n_req] = 8'h77;
        launch(1'b1, 1'b1, 7'h5B, 8'h33, 8'd1);
        repeat (100) @(negedge clk);
        @(posedge clk); #1 start_read = 1'b1;
        @(posedge clk); #1 start_read = 1'b0;
        wait_idle("both_done");
        check("both_starts", n_start - s0, 1);
        check("both_nbytes", n_log - l0, 3);
        check("both_byte0", log_b[l0], 8'hB6);
        check("both_byte2", log_b[l0 + 2], 8'h77);
        check("both_reqs", n_req - q0, 1);
        check("both_rdv", n_rdv - v0, 0);
        repeat (30) @(negedge clk);
        check("both_stays_idle", busy, 1'b0);
        check("both_stops", n_stop - p0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_core.md
I2C_MASTER_CORE -- requirements
Module: i2c_master_core

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, SCL quarter-period in clock cycles (100 kHz SCL at 100 MHz).
REQ-002 SHALL have parameter MAX_BYTES, default 255, upper bound on data bytes per transaction.
REQ-003 SHALL have port S_AXI_ACLK  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port S_AXI_ARESET  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start_write  in  1  one-cycle pulse that launches a write transaction.
REQ-006 SHALL have port start_read  in  1  one-cycle pulse that launches a register-read transaction.
REQ-007 SHALL have port dev_addr  in  7  7-bit target address, sampled at start.
REQ-008 SHALL have port reg_addr  in  8  target register address, sampled at start.
REQ-009 SHALL have port num_bytes  in  8  data byte count, sampled at start.
REQ-010 SHALL have port wr_data  in  8  next write byte, valid while req_data_chunk is high.
REQ-011 SHALL have port req_data_chunk  out  1  request for the next wr_data byte.
REQ-012 SHALL have port rd_data  out  8  last received byte.
REQ-013 SHALL have port rd_valid  out  1  one-cycle strobe qualifying rd_data.
REQ-014 SHALL have port busy  out  1  transaction in progress.
REQ-015 SHALL have port nack  out  1  sticky flag: the last transaction aborted on a NACK.
REQ-016 SHALL have ports scl_io and sda_io  inout  1 each  open-drain bus lines: drive 0 or release to Z, never drive 1.

Function
REQ-017 SHALL generate a one-cycle tick every CLK_DIV cycles while busy; each SCL bit period SHALL span 4 ticks (SCL low, low, high, high), SDA changing only in the first low quarter.
REQ-018 SHALL use FSM states IDLE, START, DEV_W, ACK1, REG, ACK2, WDATA, ACKW, RSTART, DEV_R, ACK3, RDATA, MACK, STOP.
REQ-019 In IDLE, a start_write or start_read SHALL latch dev_addr, reg_addr and num_bytes, clear nack, set busy on the next cycle and enter START.
REQ-020 If start_write and start_read are both high in the same cycle, start_write SHALL win.
REQ-021 start pulses while busy SHALL be ignored.
REQ-022 START SHALL pull SDA low while SCL is high, then SCL low.
REQ-023 DEV_W SHALL send {dev_addr,0}, MSB first; ACK1 SHALL sample SDA at SCL-high mid-point; REG/ACK2 SHALL do the same for reg_addr.
REQ-024 Write path: with num_bytes=0, ACK2 SHALL go to STOP; otherwise req_data_chunk SHALL pulse for one cycle at ACK2 and at each ACKW, wr_data SHALL be captured on the following cycle, and WDATA/ACKW SHALL repeat num_bytes times.
REQ-025 Read path: ACK2 SHALL go to RSTART (repeated start), then DEV_R sends {dev_addr,1}, ACK3, then RDATA shifts in max(num_bytes,1) bytes, MSB first.
REQ-026 rd_valid SHALL pulse once per received byte, coincident with rd_data update at the end of bit 0.
REQ-027 MACK SHALL drive ACK (SDA low) after each byte except the last, which SHALL get NACK (SDA released).
REQ-028 Any SDA-high sample in ACK1/ACK2/ACK3/ACKW SHALL set nack and go to STOP.
REQ-029 STOP SHALL release SCL, then release SDA while SCL is high, then return to IDLE, with busy falling on the IDLE entry cycle.
REQ-030 The byte counter SHALL be 8-bit, SHALL decrement per data byte and SHALL never wrap; num_bytes > MAX_BYTES SHALL be clamped to MAX_BYTES.

Reset
REQ-031 Asserting S_AXI_ARESET at any time, including mid-transaction, SHALL immediately return the FSM to IDLE and release both bus lines (Z) without issuing a STOP.
REQ-032 Reset values: busy=0, nack=0, req_data_chunk=0, rd_valid=0, rd_data=0x00, tick counter=0.

Structure
REQ-033 Package i2c_pkg SHALL hold the FSM state enum and the quarter-phase and R/W bit constants.
REQ-034 The tick/quarter-phase generator SHALL be sub-module i2c_clk_gen (inputs: enable and CLK_DIV; outputs: tick and 2-bit phase).

Verification
REQ-035 Write dev 0x5B, reg 0x00, num_bytes 0, slave ACKs -> bus bytes 0xB6 then 0x00, STOP, busy low, nack 0.
REQ-036 Write dev 0x5B, reg 0x10, num_bytes 2, wr_data 0xA5 then 0x3C -> exactly 2 req_data_chunk pulses; bus bytes 0xB6, 0x10, 0xA5, 0x3C.
REQ-037 Read dev 0x5B, reg 0x05, num_bytes 2, slave returns 0xAB, 0xCD -> repeated start, 0xB7 on bus, two rd_valid pulses with rd_data 0xAB then 0xCD, master ACK then NACK.
REQ-038 Slave NACKs the address byte -> nack=1, STOP issued, no req_data_chunk pulse, busy low.
REQ-039 Assert S_AXI_ARESET during the REG byte -> next cycle scl_io=Z, sda_io=Z, busy=0; a following start_write completes normally.
REQ-040 Pulse start_write and start_read together, then start_read while busy -> a write transaction runs and the second pulse is ignored.
